pwl_function_unit: RTL
======================

Name: pwl_function_unit

Overview:
- Parametrised successor to the single-function exponential evaluator. Evaluates y = slope[i]*x + intercept[i] over a runtime-loadable table of SEGS segments, using signed fixed-point arithmetic.
- Segment lookup is a binary search over sorted breakpoints, replacing the linear scan. Multiply-add and saturation are internal, so no vendor FP IP is needed.
- Sits where the exponential/logarithm units sit. The table contents select which function is evaluated.

Parameters:
DATA_W, 32, width of x, y, breakpoint, slope, intercept (signed two's complement)
FRAC_W, 16, fractional bits of every fixed-point quantity
SEGS, 32, number of table segments; power of two, >= 2
SEG_W, $clog2(SEGS), segment index width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  x operand valid
in_ready  output  1  unit accepts x this cycle
in_data  input  DATA_W  x operand
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  y result
out_underflow  output  1  x < breakpoint[0]; segment 0 was used
out_saturated  output  1  result clipped to DATA_W range
tbl_we  input  1  table write strobe
tbl_ready  output  1  table write accepted this cycle
tbl_sel  input  2  0 breakpoint, 1 slope, 2 intercept, 3 ignored
tbl_addr  input  SEG_W  segment index
tbl_wdata  input  DATA_W  write data

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - out_valid, out_data, out_underflow and out_saturated all go to 0.
  - Table RAM is not reset. It keeps its contents across reset, and software loads it before use.
- States: IDLE, SEARCH, MUL, ADD, HOLD.
- tbl_ready = (state == IDLE).
  - A write occurs on tbl_we & tbl_ready, to entry tbl_addr, field tbl_sel.
  - tbl_we outside IDLE is dropped.
  - tbl_sel = 3 performs no write.
- in_ready = (IDLE & !tbl_we) | (HOLD & out_ready). A table write has priority over an operand in the same IDLE cycle.
- Accept (in_valid & in_ready):
  - Latch x; idx <= 0; bit <= SEG_W-1.
  - Latch underflow = (x < bp[0]).
  - Go to SEARCH.
- SEARCH: one cycle per bit, SEG_W cycles in total.
  - cand = idx | (1 << bit).
  - If bp[cand] <= x (signed compare), idx <= cand.
  - At bit 0, go to MUL.
  - Result: idx is the largest i with bp[i] <= x; idx is 0 if none.
  - Breakpoints must be strictly ascending. Unsorted tables give an undefined segment but no hang.
- MUL: prod <= slope[idx] * x, full 2*DATA_W signed.
- ADD:
  - sum = (prod >>> FRAC_W) + sign-extended intercept[idx]. The shift is arithmetic, truncating toward -inf.
  - If sum > 2^(DATA_W-1)-1: out_data = 0x7FF..F and sat = 1.
  - If sum < -2^(DATA_W-1): out_data = 0x800..0 and sat = 1.
  - Otherwise out_data = sum and sat = 0.
  - Register out_data and the flags, set out_valid, go to HOLD.
- HOLD: out_data and the flags stay stable while out_valid & !out_ready.
  - out_ready with in_valid: accept the new x the same cycle, go to SEARCH, clear out_valid.
  - out_ready without in_valid: go to IDLE, clear out_valid.
- Latency: out_valid rises SEG_W+2 cycles after the accept edge (7 at default).
- Throughput: one result per SEG_W+3 cycles with out_ready held high.
- x above the last breakpoint uses segment SEGS-1 and raises no flag.
- Reset asserted mid-operation aborts immediately. No partial result is emitted.

Test Plan:
- Defaults; load bp[i]=(i-16)<<16, slope[i]=i<<16, intercept[i]=0x00008000; x=0x00028000 (2.5), out_ready=1 -> segment 18; out_data=0x002D8000 (45.5), flags 0; out_valid exactly 7 cycles after accept.
- Same table; x=0xFFEC0000 (-20.0) -> segment 0; out_data=0x00008000, out_underflow=1. x=0x00640000 (100.0) -> segment 31; out_data=0x0C1C8000, no flags.
- Write slope[31]=0x7FFF0000; x=100.0 -> out_data=0x7FFFFFFF, out_saturated=1. Write intercept[31]=0x80000000 and slope[31]=0xFFFF0000 (-1.0), x=100.0 -> out_data=0x80000000, out_saturated=1.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 -> accepted in that cycle, out_valid low next cycle, next result 7 cycles later.
- tbl_we during SEARCH -> tbl_ready=0, entry unchanged (read back via evaluation). tbl_we and in_valid together in IDLE -> write done, in_ready=0, operand accepted next cycle.
- Assert reset 3 cycles into SEARCH -> out_valid=0 asynchronously, state IDLE, no result emitted. After release, 2.5 re-evaluates to 0x002D8000 with the table retained.

Source files
------------

// File: rtl/pwl_function_unit_if.sv
// Handshake and table-load bundle for the piecewise-linear function unit.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface pwl_function_unit_if #(
    parameter int DATA_W = 32,
    parameter int SEG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_underflow;
    logic              out_saturated;
    logic              tbl_we;
    logic              tbl_ready;
    logic [1:0]        tbl_sel;
    logic [SEG_W-1:0]  tbl_addr;
    logic [DATA_W-1:0] tbl_wdata;

    modport slave (
        input  in_valid, in_data, out_ready, tbl_we, tbl_sel, tbl_addr, tbl_wdata,
        output in_ready, out_valid, out_data, out_underflow, out_saturated, tbl_ready
    );

    modport master (
        output in_valid, in_data, out_ready, tbl_we, tbl_sel, tbl_addr, tbl_wdata,
        input  in_ready, out_valid, out_data, out_underflow, out_saturated, tbl_ready
    );
endinterface

// File: rtl/pwl_function_unit.sv
// Piecewise-linear evaluator: y = slope[i]*x + intercept[i], segment i found by a
// binary search over a runtime-loaded breakpoint table, with saturating signed output.
module pwl_function_unit #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int SEGS   = 32
) (
    input logic                clock,
    input logic                reset,
    pwl_function_unit_if.slave bus
);
    localparam int SEG_W = $clog2(SEGS);

    typedef logic signed [DATA_W-1:0]   word_t;
    typedef logic signed [2*DATA_W-1:0] wide_t;
    typedef logic [SEG_W-1:0]           seg_t;
    typedef enum logic [2:0] {IDLE, SEARCH, MUL, ADD, HOLD} state_t;

    localparam wide_t MAX_W = wide_t'({1'b0, {(DATA_W-1){1'b1}}});
    localparam wide_t MIN_W = -MAX_W - wide_t'(1);

    state_t state_q, state_d;
    word_t  x_q, x_d;
    seg_t   idx_q, idx_d;
    seg_t   bitPos_q, bitPos_d;
    logic   underflow_q, underflow_d;
    wide_t  prod_q, prod_d;
    word_t  yData_q, yData_d;
    logic   yUnder_q, yUnder_d;
    logic   ySat_q, ySat_d;
    logic   yValid_q, yValid_d;

    word_t  bp_q    [SEGS];
    word_t  slope_q [SEGS];
    word_t  icpt_q  [SEGS];

    seg_t   cand;
    wide_t  shifted;
    wide_t  icptExt;
    wide_t  sum;
    logic   inReady;
    logic   accept;

    assign inReady = ((state_q == IDLE) && !bus.tbl_we) || ((state_q == HOLD) && bus.out_ready);
    assign accept  = bus.in_valid && inReady;
    assign cand    = idx_q | (seg_t'(1) << bitPos_q);
    assign shifted = prod_q >>> FRAC_W;
    assign icptExt = wide_t'(icpt_q[idx_q]);
    assign sum     = shifted + icptExt;

    // Table storage has no reset: software reloads it, and contents survive a reset.
    always_ff @(posedge clock) begin
        if (bus.tbl_we && (state_q == IDLE)) begin
            case (bus.tbl_sel)
                2'd0:    bp_q[bus.tbl_addr]    <= word_t'(bus.tbl_wdata);
                2'd1:    slope_q[bus.tbl_addr] <= word_t'(bus.tbl_wdata);
                2'd2:    icpt_q[bus.tbl_addr]  <= word_t'(bus.tbl_wdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            idx_q       <= '0;
            bitPos_q    <= '0;
            underflow_q <= 1'b0;
            prod_q      <= '0;
            yData_q     <= '0;
            yUnder_q    <= 1'b0;
            ySat_q      <= 1'b0;
            yValid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            idx_q       <= idx_d;
            bitPos_q    <= bitPos_d;
            underflow_q <= underflow_d;
            prod_q      <= prod_d;
            yData_q     <= yData_d;
            yUnder_q    <= yUnder_d;
            ySat_q      <= ySat_d;
            yValid_q    <= yValid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        idx_d       = idx_q;
        bitPos_d    = bitPos_q;
        underflow_d = underflow_q;
        prod_d      = prod_q;
        yData_d     = yData_q;
        yUnder_d    = yUnder_q;
        ySat_d      = ySat_q;
        yValid_d    = yValid_q;

        case (state_q)
            SEARCH: begin
                if (bp_q[cand] <= x_q) idx_d = cand;
                if (bitPos_q == '0) state_d = MUL;
                else                bitPos_d = bitPos_q - seg_t'(1);
            end
            MUL: begin
                prod_d  = slope_q[idx_q] * x_q;
                state_d = ADD;
            end
            ADD: begin
                if (sum > MAX_W) begin
                    yData_d = word_t'({1'b0, {(DATA_W-1){1'b1}}});
                    ySat_d  = 1'b1;
                end else if (sum < MIN_W) begin
                    yData_d = word_t'({1'b1, {(DATA_W-1){1'b0}}});
                    ySat_d  = 1'b1;
                end else begin
                    yData_d = word_t'(sum[DATA_W-1:0]);
                    ySat_d  = 1'b0;
                end
                yUnder_d = underflow_q;
                yValid_d = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    yValid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: ;
        endcase

        // An accepted operand overrides the HOLD->IDLE exit so back-to-back work skips IDLE.
        if (accept) begin
            x_d         = $signed(bus.in_data);
            idx_d       = '0;
            bitPos_d    = seg_t'(SEG_W - 1);
            underflow_d = ($signed(bus.in_data) < bp_q[0]);
            state_d     = SEARCH;
        end
    end

    assign bus.in_ready      = inReady;
    assign bus.tbl_ready     = (state_q == IDLE);
    assign bus.out_valid     = yValid_q;
    assign bus.out_data      = yData_q;
    assign bus.out_underflow = yUnder_q;
    assign bus.out_saturated = ySat_q;
endmodule
